// File: rtl/deck_shuffler_pkg.sv
// ============================================================================
// deck_shuffler_pkg
// Shared definitions for the deck shuffler block.
//   DECK_SIZE : default number of cards held in the deck
//   CARD_W    : default card-code / deck-address width
//   state_t   : shuffle controller state encoding
// ============================================================================
package deck_shuffler_pkg;

    localparam int DECK_SIZE = 52;
    localparam int CARD_W    = 6;

    // ADDR presents index i to the next-address stage, SWAP performs the
    // exchange, DONE announces the end of the shuffle for one cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        SWAP = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage : deck_shuffler_pkg

// File: rtl/deck_shuffler_ram.sv
// ============================================================================
// deck_ram
// DECK_SIZE x CARD_W register array holding the deck.
//   clk, rst_n       : clock, asynchronous active-low reset (identity deck)
//   swap_en          : exchange mem[addr_a] and mem[addr_b] on the next edge
//   addr_a, addr_b   : asynchronous read addresses (also the swap addresses)
//   rdata_a, rdata_b : asynchronous read data (0 for out-of-range addresses)
// The caller guarantees that addr_a != addr_b and both are in range whenever
// swap_en is high.
// ============================================================================
module deck_ram #(
    parameter int DECK_SIZE = deck_shuffler_pkg::DECK_SIZE,
    parameter int CARD_W    = deck_shuffler_pkg::CARD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              swap_en,
    input  logic [CARD_W-1:0] addr_a,
    input  logic [CARD_W-1:0] addr_b,
    output logic [CARD_W-1:0] rdata_a,
    output logic [CARD_W-1:0] rdata_b
);

    localparam logic [CARD_W-1:0] FULL_CNT = CARD_W'(DECK_SIZE);

    logic [CARD_W-1:0] mem [DECK_SIZE];

    // Addresses beyond the deck read as 0 rather than indexing past the array.
    assign rdata_a = (addr_a < FULL_CNT) ? mem[addr_a] : '0;
    assign rdata_b = (addr_b < FULL_CNT) ? mem[addr_b] : '0;

    // NOTE: this array is deliberately built from flops, not a RAM macro, so
    // every entry can be reset to its own index and two entries can be written
    // in the same edge; a RAM could do neither.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DECK_SIZE; k++) begin
                mem[k] <= CARD_W'(k);
            end
        end else if (swap_en) begin
            // NOTE: non-blocking assignments make both writes use the values
            // read before the edge, which is exactly a swap; blocking ones
            // would copy one card over the other.
            mem[addr_a] <= rdata_b;
            mem[addr_b] <= rdata_a;
        end
    end

endmodule : deck_ram

// File: rtl/deck_shuffler.sv
// ============================================================================
// deck_shuffler
// Fisher-Yates style deck shuffler with an external next-address stage and a
// sequential dealer.
//   clk, rst_n    : clock, asynchronous active-low reset (identity deck)
//   shuffle_start : one-cycle shuffle request, honoured only in IDLE
//   addr_i        : swap index presented to the next-address stage
//   addr_j        : swap partner returned combinationally for addr_i
//   deal_req      : request for the next card, honoured only in IDLE
//   card_valid    : one-cycle pulse qualifying card
//   card          : dealt card code, held between deals
//   deck_empty    : all DECK_SIZE cards have been dealt
//   busy          : shuffle in progress (ADDR, SWAP, DONE)
//   shuffle_done  : one-cycle pulse while in DONE
// Build option: define SHUFFLE_DOUBLE_PASS_EN to run the index sweep twice per
// shuffle request; undefined gives a single sweep.
// ============================================================================
module deck_shuffler #(
    parameter int DECK_SIZE = deck_shuffler_pkg::DECK_SIZE,
    parameter int CARD_W    = deck_shuffler_pkg::CARD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shuffle_start,
    output logic [CARD_W-1:0] addr_i,
    input  logic [CARD_W-1:0] addr_j,
    input  logic              deal_req,
    output logic              card_valid,
    output logic [CARD_W-1:0] card,
    output logic              deck_empty,
    output logic              busy,
    output logic              shuffle_done
);

    import deck_shuffler_pkg::*;

`ifdef SHUFFLE_DOUBLE_PASS_EN
    localparam bit DOUBLE_PASS = 1'b1;
`else
    localparam bit DOUBLE_PASS = 1'b0;
`endif

    // The deal pointer must be able to reach DECK_SIZE, so DECK_SIZE is
    // expected to be below 2**CARD_W.
    localparam logic [CARD_W-1:0] LAST_IDX = CARD_W'(DECK_SIZE - 1);
    localparam logic [CARD_W-1:0] FULL_CNT = CARD_W'(DECK_SIZE);

    state_t            state;
    logic [CARD_W-1:0] i;
    logic [CARD_W-1:0] j_q;
    logic [CARD_W-1:0] ptr;
    logic              pass;

    logic              swap_en;
    logic [CARD_W-1:0] rd_addr_a;
    logic [CARD_W-1:0] rdata_a;
    logic [CARD_W-1:0] rdata_b;

    // Port A serves the dealer while idle and the swap index otherwise;
    // port B always looks at the registered partner j_q.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the block can leave it unassigned and infer a latch.
        rd_addr_a = i;
        swap_en   = 1'b0;
        if (state == IDLE) begin
            rd_addr_a = ptr;
        end
        if (state == SWAP && j_q < FULL_CNT && j_q != i) begin
            swap_en = 1'b1;
        end
    end

    deck_ram #(
        .DECK_SIZE (DECK_SIZE),
        .CARD_W    (CARD_W)
    ) u_deck_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .swap_en (swap_en),
        .addr_a  (rd_addr_a),
        .addr_b  (j_q),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b)
    );

    assign deck_empty = (ptr == FULL_CNT);

    // Controller with registered outputs: busy, addr_i and shuffle_done are
    // set on the transitions into the states they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            i            <= '0;
            j_q          <= '0;
            ptr          <= '0;
            pass         <= 1'b0;
            busy         <= 1'b0;
            shuffle_done <= 1'b0;
            card_valid   <= 1'b0;
            card         <= '0;
            addr_i       <= '0;
        end else begin
            shuffle_done <= 1'b0;
            card_valid   <= 1'b0;
            case (state)
                IDLE: begin
                    // A shuffle request takes priority over a deal request.
                    if (shuffle_start) begin
                        i      <= '0;
                        addr_i <= '0;
                        pass   <= 1'b0;
                        busy   <= 1'b1;
                        state  <= ADDR;
                    end else if (deal_req && !deck_empty) begin
                        card_valid <= 1'b1;
                        card       <= rdata_a;
                        ptr        <= ptr + 1'b1;
                    end
                end
                ADDR: begin
                    j_q   <= addr_j;
                    state <= SWAP;
                end
                SWAP: begin
                    if (i != LAST_IDX) begin
                        i      <= i + 1'b1;
                        addr_i <= i + 1'b1;
                        state  <= ADDR;
                    end else if (DOUBLE_PASS && !pass) begin
                        pass   <= 1'b1;
                        i      <= '0;
                        addr_i <= '0;
                        state  <= ADDR;
                    end else begin
                        addr_i       <= '0;
                        shuffle_done <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    ptr   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : deck_shuffler

// File: tb/tb_deck_shuffler.sv
// ============================================================================
// tb_deck_shuffler
// Self-checking bench for deck_shuffler. The reference model keeps the deck as
// a plain array and applies the swap rule for each index of each pass.
// ============================================================================
module tb_deck_shuffler;

    localparam int N = 52;
    localparam int W = 6;
`ifdef SHUFFLE_DOUBLE_PASS_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif
    localparam int EXP_DONE = PASSES * 2 * N + 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         shuffle_start;
    logic [W-1:0] addr_i;
    logic [W-1:0] addr_j;
    logic         deal_req;
    logic         card_valid;
    logic [W-1:0] card;
    logic         deck_empty;
    logic         busy;
    logic         shuffle_done;

    int checks = 0;
    int errors = 0;

    // Next-address stage emulation: 0 mirror, 1 constant, 2 lookup table.
    int mode      = 0;
    int const_j   = 0;
    int j_tab [N];
    int model_deck [N];

    always #5 clk = ~clk;

    deck_shuffler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .shuffle_start (shuffle_start),
        .addr_i        (addr_i),
        .addr_j        (addr_j),
        .deal_req      (deal_req),
        .card_valid    (card_valid),
        .card          (card),
        .deck_empty    (deck_empty),
        .busy          (busy),
        .shuffle_done  (shuffle_done)
    );

    function automatic int j_of(input int idx);
        int r;
        r = idx;
        if (mode == 1) r = const_j;
        else if (mode == 2) r = (idx < N) ? j_tab[idx] : 0;
        return r;
    endfunction

    always_comb begin
        addr_j = '0;
        addr_j = W'(j_of(int'(addr_i)));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) model_deck[k] = k;
    endtask

    task automatic model_shuffle();
        int j, t;
        for (int p = 0; p < PASSES; p++) begin
            for (int k = 0; k < N; k++) begin
                j = j_of(k);
                if (j < N && j != k) begin
                    t = model_deck[k];
                    model_deck[k] = model_deck[j];
                    model_deck[j] = t;
                end
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(shuffle_done), 0);
        check("rst_valid", 32'(card_valid), 0);
        check("rst_card", 32'(card), 0);
        check("rst_addr_i", 32'(addr_i), 0);
        check("rst_empty", 32'(deck_empty), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Samples at the falling edge of cycle n (between rising edges n-1 and n),
    // where the rising edge that captures shuffle_start is edge 0.
    task automatic run_shuffle(input string tag, input bit deal_during, input bit stray);
        int done_at = -1;
        int done_cnt = 0;
        int busy_cnt = 0;
        int valid_seen = 0;
        @(negedge clk);
        shuffle_start = 1'b1;
        deal_req      = deal_during;
        for (int n = 1; n <= 600; n++) begin
            @(negedge clk);
            if (card_valid) valid_seen++;
            if (busy) busy_cnt++;
            if (shuffle_done) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
            if (!busy && n > 1) break;
            shuffle_start = stray && (n < EXP_DONE - 1) && ($urandom_range(0, 7) == 0);
        end
        shuffle_start = 1'b0;
        deal_req      = 1'b0;
        check({tag, "_done_cycle"}, 32'(done_at), 32'(EXP_DONE));
        check({tag, "_done_pulses"}, 32'(done_cnt), 1);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(EXP_DONE));
        check({tag, "_no_valid"}, 32'(valid_seen), 0);
        check({tag, "_addr_i_idle"}, 32'(addr_i), 0);
        check({tag, "_not_empty"}, 32'(deck_empty), 0);
        model_shuffle();
    endtask

    task automatic deal_all(input string tag);
        deal_req = 1'b1;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            check($sformatf("%s_card%0d", tag, k), {26'd0, card_valid, card},
                  {26'd0, 1'b1, W'(model_deck[k])});
        end
        deal_req = 1'b0;
        @(negedge clk);
        check({tag, "_empty"}, 32'(deck_empty), 1);
        check({tag, "_valid_low"}, 32'(card_valid), 0);
        // Further requests on an empty deck are dropped and card holds.
        deal_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        deal_req = 1'b0;
        check({tag, "_empty_drop"}, 32'(card_valid), 0);
        check({tag, "_card_hold"}, 32'(card), 32'(model_deck[N-1]));
        check({tag, "_still_empty"}, 32'(deck_empty), 1);
    endtask

    initial begin
        rst_n         = 1'b1;
        shuffle_start = 1'b0;
        deal_req      = 1'b0;
        for (int k = 0; k < N; k++) j_tab[k] = 0;
        model_reset();

        apply_reset();

        // Mirror: every swap partner equals the index, deck stays identity.
        mode = 0;
        run_shuffle("mirror", 1'b0, 1'b0);
        deal_all("mirror");

        // Constant partner 51 from a fresh identity deck.
        apply_reset();
        mode = 1; const_j = 51;
        run_shuffle("j51", 1'b1, 1'b0);
        deal_all("j51");

        // Out-of-range partner: every swap skipped.
        apply_reset();
        mode = 1; const_j = 60;
        run_shuffle("j60", 1'b0, 1'b1);
        deal_all("j60");

        // Reset in cycle 40 of a shuffle abandons it.
        mode = 1; const_j = 51;
        @(negedge clk);
        shuffle_start = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            shuffle_start = 1'b0;
        end
        check("midrst_busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_addr_i", 32'(addr_i), 0);
        check("midrst_empty", 32'(deck_empty), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        deal_all("midrst");

        // Random partner tables, including out-of-range codes, applied to the
        // deck left by the previous shuffle.
        mode = 2;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < N; k++) j_tab[k] = int'($urandom_range(0, 63));
            run_shuffle($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), 1'b1);
            deal_all($sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_deck_shuffler

// File: doc/deck_shuffler.md
DECK_SHUFFLER -- requirements
Module: deck_shuffler

Interface
REQ-001 SHALL have parameter DECK_SIZE, default 52, number of cards held.
REQ-002 SHALL have parameter CARD_W, default 6, card code and address width.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port shuffle_start, input, 1, one-cycle request to shuffle the deck.
REQ-006 SHALL have port addr_i, output, CARD_W, current swap index driven to the next-address stage.
REQ-007 SHALL have port addr_j, input, CARD_W, swap partner returned combinationally by the next-address stage.
REQ-008 SHALL have port deal_req, input, 1, request for the next card.
REQ-009 SHALL have port card_valid, output, 1, one-cycle pulse qualifying card.
REQ-010 SHALL have port card, output, CARD_W, dealt card code.
REQ-011 SHALL have port deck_empty, output, 1, high when all DECK_SIZE cards have been dealt.
REQ-012 SHALL have port busy, output, 1, high while shuffling.
REQ-013 SHALL have port shuffle_done, output, 1, one-cycle pulse at shuffle end.

Function
REQ-014 SHALL implement FSM states IDLE, ADDR, SWAP and DONE.
REQ-015 IDLE with shuffle_start=1 SHALL clear index i to 0 and go to ADDR; shuffle_start outside IDLE is ignored.
REQ-016 ADDR SHALL drive addr_i=i, register addr_j into j_q, and go to SWAP.
REQ-017 SHALL, in SWAP with j_q<DECK_SIZE, exchange deck[i] and deck[j_q] in one edge; j_q>=DECK_SIZE or j_q==i skips the swap.
REQ-018 SWAP SHALL go to ADDR with i+1 when i<DECK_SIZE-1; otherwise it goes to DONE.
REQ-019 DONE SHALL pulse shuffle_done, clear deal pointer ptr to 0, and return to IDLE.
REQ-020 Single-pass latency SHALL be: start sampled at edge 0, busy high edges 1..105, shuffle_done high in cycle 105.
REQ-021 busy SHALL be high in ADDR, SWAP and DONE; addr_i SHALL hold 0 outside ADDR/SWAP.
REQ-022 In IDLE, deal_req with deck_empty=0 SHALL give card_valid=1 and card=deck[ptr] on the next cycle, then increment ptr.
REQ-023 deck_empty SHALL equal (ptr==DECK_SIZE); ptr SHALL saturate and never wrap.
REQ-024 deal_req while busy or empty SHALL be dropped with no card_valid; shuffle_start and deal_req together in IDLE: shuffle wins, deal dropped.
REQ-025 card SHALL hold its last value when card_valid=0.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, deck[k]=k for all k, ptr=0, i=0, j_q=0.
REQ-027 rst_n low SHALL immediately force busy=0, shuffle_done=0, card_valid=0, card=0, addr_i=0, and deck_empty=0.
REQ-028 Reset mid-shuffle SHALL abandon the shuffle and restore the identity deck.

Configuration
REQ-029 Macro SHUFFLE_DOUBLE_PASS_EN defined SHALL make the shuffle run two full passes (i 0..51 twice, 208 ADDR/SWAP cycles, shuffle_done in cycle 209); undefined SHALL give one pass per REQ-020.

Structure
REQ-030 Shared package SHALL hold DECK_SIZE, CARD_W and the FSM state encoding.
REQ-031 Sub-module deck_ram SHALL hold the DECK_SIZE x CARD_W register array, with two async read ports, dual-write swap, and identity reset.

Verification
REQ-032 Bench SHALL cover: addr_j mirrors addr_i, start -> shuffle_done in cycle 105; 52 deals yield 0..51 in order, then deck_empty=1.
REQ-033 Bench SHALL cover: addr_j tied to 51, one shuffle -> deal order 51,0,1,...,50.
REQ-034 Bench SHALL cover: addr_j tied to 60 (out of range) -> identity deck, shuffle_done still in cycle 105.
REQ-035 Bench SHALL cover: deal_req during busy and after 52 deals -> no card_valid, ptr unchanged.
REQ-036 Bench SHALL cover: rst_n low at cycle 40 of a shuffle -> busy=0 at once, deal order 0..51.
REQ-037 Bench SHALL cover: with SHUFFLE_DOUBLE_PASS_EN and addr_j tied to 51, one shuffle -> shuffle_done in cycle 209, deal order 50,51,0,...,49.
